// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end.
// Holds the sequencer state encoding and the buffered fetch entry.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [63:0] word_index(input logic [63:0] byte_pc);
        return {2'b00, byte_pc[63:2]};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetch entries between the memory return path
// and decode; flush empties it in one cycle.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slots [2];
    logic         rd_ptr;
    logic         wr_ptr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Payload storage needs no reset; count qualifies it.
    always_ff @(posedge clk) begin
        if (push) slots[wr_ptr] <= push_entry;
    end

    assign head = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            assert (!(push && !pop && count == 2'd2));
            assert (!(pop && count == 2'd0));
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: issues word addresses to a one-cycle synchronous
// IMEM and hands {pc, instr} to decode through a 2-entry buffer.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_DEPTH = 1024,
    parameter int          BUF_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_instruction,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fault,
    output logic        busy
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [63:0]  pc;
    logic [63:0]  issued_pc;
    logic         inflight;
    logic         fault_next;
    logic [1:0]   count;
    logic [2:0]   credits;
    logic         pc_in_range;
    logic         target_in_range;
    logic         target_aligned;
    logic         fetch_slot;
    logic         issue;
    logic         range_fault;
    logic         push;
    logic         pop;
    fetch_entry_t head;
    fetch_entry_t push_entry;

    assign pc_in_range     = pc[63:2] < 62'(IMEM_DEPTH);
    assign target_in_range = redirect_pc[63:2] < 62'(IMEM_DEPTH);
    assign target_aligned  = redirect_pc[1:0] == 2'b00;

    // A slot is free if an entry leaves this cycle, even while one returns.
    assign credits = 3'(BUF_DEPTH) - {1'b0, count}
                   - {2'b00, inflight} + {2'b00, pop};

    always_comb begin
        state_next  = state;
        fault_next  = fault;
        fetch_slot  = (state == RUN) && !redirect_valid && !stop
                   && (credits != 3'd0);
        issue       = fetch_slot && pc_in_range;
        range_fault = fetch_slot && !pc_in_range;
        if (redirect_valid && state != IDLE) begin
            if (!target_aligned) begin
                state_next = FAULT;
                fault_next = 1'b1;
            end else if (state == RUN || target_in_range) begin
                state_next = RUN;
                fault_next = 1'b0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) state_next = RUN;
                end
                RUN: begin
                    if (stop) begin
                        state_next = IDLE;
                    end else if (range_fault) begin
                        state_next = FAULT;
                        fault_next = 1'b1;
                    end
                end
                FAULT: state_next = FAULT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            issued_pc <= 64'd0;
            inflight  <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state    <= state_next;
            fault    <= fault_next;
            inflight <= issue;
            if (redirect_valid) pc <= redirect_pc;
            else if (issue)     pc <= pc + 64'd4;
            if (issue) issued_pc <= pc;
        end
    end

    // Returning data is dropped on a redirect together with the buffer.
    assign push             = inflight && !redirect_valid;
    assign push_entry.pc    = issued_pc;
    assign push_entry.instr = imem_instruction;

    assign out_valid = (count != 2'd0) && !redirect_valid;
    assign pop       = out_valid && out_ready;

    fetch_buffer u_buffer (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    assign imem_addr = word_index(pc);
    assign imem_en   = issue;
    assign out_pc    = out_valid ? head.pc : 64'd0;
    assign out_instr = out_valid ? head.instr : 32'd0;
    assign busy      = (state == RUN) || inflight;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(imem_en && state != RUN));
            assert ({1'b0, count} + {2'b00, inflight} <= 3'd2);
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus a randomized
// stream checked against a sequential-PC scoreboard.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic [63:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_instruction;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fault;
    logic        busy;

    logic [31:0] mem [1024];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_instruction <= mem[imem_addr[9:0]];

    fetch_controller dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .stop             (stop),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_addr        (imem_addr),
        .imem_en          (imem_en),
        .imem_instruction (imem_instruction),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_pc           (out_pc),
        .fault            (fault),
        .busy             (busy)
    );

    // step: move to the drive point of the next cycle; look: sample point
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        look();
        total++;
        if ({out_valid, busy, fault, imem_en} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {out_valid, busy, fault, imem_en});
        end
        total++;
        if (imem_addr !== 64'd0) begin
            bad++;
            $display("FAIL reset_addr got=%h exp=0", imem_addr);
        end
        total++;
        if ({out_pc, out_instr} !== 96'd0) begin
            bad++;
            $display("FAIL reset_out got=%h/%h exp=0", out_pc, out_instr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        look();
        total++;
        if (!(imem_en === 1'b1 && imem_addr === 64'd0 && out_valid === 1'b0)) begin
            bad++;
            $display("FAIL stream_issue0 got en=%b addr=%h v=%b exp en=1 addr=0 v=0",
                     imem_en, imem_addr, out_valid);
        end
        step();
        look();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_latency got=%b exp=0", out_valid);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            look();
            total++;
            if (!(out_valid === 1'b1 && out_pc === 64'(4 * k)
                  && out_instr === mem[k])) begin
                bad++;
                $display("FAIL stream_out%0d got v=%b pc=%h i=%h exp pc=%h i=%h",
                         k, out_valid, out_pc, out_instr, 4 * k, mem[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            look();
            if (imem_en) n++;
            if (i >= 2) begin
                total++;
                if (!(out_valid === 1'b1 && out_pc === 64'd0)) begin
                    bad++;
                    $display("FAIL bp_hold%0d got v=%b pc=%h exp v=1 pc=0",
                             i, out_valid, out_pc);
                end
            end
            step();
        end
        total++;
        if (n != 2) begin
            bad++;
            $display("FAIL bp_issues got=%0d exp=2", n);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            look();
            total++;
            if (!(out_valid === 1'b1 && out_pc === 64'(4 * k)
                  && out_instr === mem[k])) begin
                bad++;
                $display("FAIL bp_drain%0d got v=%b pc=%h exp pc=%h",
                         k, out_valid, out_pc, 4 * k);
            end
            step();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        look();
        total++;
        if (!(out_valid === 1'b1 && out_pc === 64'd0)) begin
            bad++;
            $display("FAIL redir_pre got v=%b pc=%h exp v=1 pc=0", out_valid, out_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h40;
        #1;
        total++;
        if ({out_valid, imem_en} !== 2'b00) begin
            bad++;
            $display("FAIL redir_hide got=%b exp=00", {out_valid, imem_en});
        end
        step();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        look();
        total++;
        if (!(imem_en === 1'b1 && imem_addr === 64'd16 && out_valid === 1'b0)) begin
            bad++;
            $display("FAIL redir_issue got en=%b addr=%h v=%b exp en=1 addr=10 v=0",
                     imem_en, imem_addr, out_valid);
        end
        step();
        look();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL redir_stale got v=%b pc=%h exp v=0", out_valid, out_pc);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            look();
            total++;
            if (!(out_valid === 1'b1 && out_pc === 64'(64 + 4 * k)
                  && out_instr === mem[16 + k])) begin
                bad++;
                $display("FAIL redir_out%0d got v=%b pc=%h i=%h exp pc=%h i=%h",
                         k, out_valid, out_pc, out_instr, 64 + 4 * k, mem[16 + k]);
            end
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 64'h42;
        look();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mis_hide got=%b exp=0", out_valid);
        end
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            look();
            total++;
            if ({fault, imem_en, busy, out_valid} !== 4'b1000) begin
                bad++;
                $display("FAIL mis_fault%0d got f/en/busy/v=%b exp=1000",
                         i, {fault, imem_en, busy, out_valid});
            end
            step();
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h8;
        step();
        redirect_valid = 1'b0;
        look();
        total++;
        if (!(fault === 1'b0 && imem_en === 1'b1 && imem_addr === 64'd2)) begin
            bad++;
            $display("FAIL mis_recover got f=%b en=%b addr=%h exp f=0 en=1 addr=2",
                     fault, imem_en, imem_addr);
        end
        step();
        step();
        look();
        total++;
        if (!(out_valid === 1'b1 && out_pc === 64'h8 && out_instr === mem[2])) begin
            bad++;
            $display("FAIL mis_resume got v=%b pc=%h exp v=1 pc=8", out_valid, out_pc);
        end
    endtask

    task automatic test_range_end();
        int high;
        do_reset();
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFC;
        step();
        redirect_valid = 1'b0;
        look();
        total++;
        if (!(imem_en === 1'b1 && imem_addr === 64'h3FF)) begin
            bad++;
            $display("FAIL end_issue got en=%b addr=%h exp en=1 addr=3ff",
                     imem_en, imem_addr);
        end
        step();
        look();
        total++;
        if ({imem_en, fault} !== 2'b00) begin
            bad++;
            $display("FAIL end_noissue got en/f=%b exp=00", {imem_en, fault});
        end
        step();
        look();
        total++;
        if (!(out_valid === 1'b1 && out_pc === 64'hFFC
              && out_instr === mem[1023] && fault === 1'b1)) begin
            bad++;
            $display("FAIL end_last got v=%b pc=%h f=%b exp v=1 pc=ffc f=1",
                     out_valid, out_pc, fault);
        end
        high = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            look();
            if (imem_en || out_valid || !fault) high++;
        end
        total++;
        if (high != 0) begin
            bad++;
            $display("FAIL end_quiet got=%0d bad cycles exp=0", high);
        end
    endtask

    task automatic test_stop();
        do_reset();
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        stop = 1'b1;
        look();
        total++;
        if (!(imem_en === 1'b0 && out_valid === 1'b1 && out_pc === 64'h4)) begin
            bad++;
            $display("FAIL stop_noissue got en=%b pc=%h exp en=0 pc=4", imem_en, out_pc);
        end
        step();
        stop = 1'b0;
        look();
        total++;
        if (!(out_valid === 1'b1 && out_pc === 64'h8 && busy === 1'b0)) begin
            bad++;
            $display("FAIL stop_drain got v=%b pc=%h busy=%b exp v=1 pc=8 busy=0",
                     out_valid, out_pc, busy);
        end
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        look();
        total++;
        if (!(imem_en === 1'b1 && imem_addr === 64'd3)) begin
            bad++;
            $display("FAIL stop_restart got en=%b addr=%h exp en=1 addr=3",
                     imem_en, imem_addr);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        look();
        total++;
        if (!(out_valid === 1'b1 && out_pc === 64'd0 && imem_en === 1'b0)) begin
            bad++;
            $display("FAIL rst_full got v=%b pc=%h en=%b exp v=1 pc=0 en=0",
                     out_valid, out_pc, imem_en);
        end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        look();
        total++;
        if (!({out_valid, busy, fault} === 3'b000 && imem_addr === 64'd0)) begin
            bad++;
            $display("FAIL rst_mid got v/busy/f=%b addr=%h exp 000 addr=0",
                     {out_valid, busy, fault}, imem_addr);
        end
        start = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            look();
            total++;
            if (!(out_valid === 1'b1 && out_pc === 64'(4 * k)
                  && out_instr === mem[k])) begin
                bad++;
                $display("FAIL rst_resume%0d got v=%b pc=%h exp pc=%h",
                         k, out_valid, out_pc, 4 * k);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] exp_pc;
        logic        do_redir;
        int          occ;
        int          got;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            redirect_valid = 1'b1;
            redirect_pc = 64'($urandom_range(0, 511)) * 64'd4;
            exp_pc = redirect_pc;
            step();
            redirect_valid = 1'b0;
            start = 1'b1;
            step();
            start = 1'b0;
            occ = 0;
            got = 0;
            for (int c = 0; c < 150; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                do_redir = ($urandom_range(0, 39) == 0);
                if (do_redir) begin
                    redirect_valid = 1'b1;
                    redirect_pc = 64'($urandom_range(0, 511)) * 64'd4;
                end
                look();
                if (do_redir) begin
                    total++;
                    if (out_valid !== 1'b0) begin
                        bad++;
                        $display("FAIL rnd_hide r%0d c%0d got=%b exp=0", r, c, out_valid);
                    end
                    occ = 0;
                end else begin
                    if (out_valid && out_ready) begin
                        total++;
                        if (!(out_pc === exp_pc && out_instr === mem[exp_pc[11:2]])) begin
                            bad++;
                            $display("FAIL rnd_out r%0d c%0d got pc=%h i=%h exp pc=%h i=%h",
                                     r, c, out_pc, out_instr, exp_pc, mem[exp_pc[11:2]]);
                        end
                        exp_pc = exp_pc + 64'd4;
                        got++;
                        occ--;
                    end
                    if (imem_en) occ++;
                    total++;
                    if (occ > 2) begin
                        bad++;
                        $display("FAIL rnd_credit r%0d c%0d got=%0d exp<=2", r, c, occ);
                    end
                end
                step();
                if (do_redir) begin
                    redirect_valid = 1'b0;
                    exp_pc = redirect_pc;
                end
            end
            total++;
            if (got < 20) begin
                bad++;
                $display("FAIL rnd_progress r%0d got=%0d exp>=20", r, got);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_range_end();
        test_stop();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
